// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage divider: data width, FSM encoding,
// stall-request levels and a conditional absolute-value helper.
package ex_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_ZERO = 2'd1,
    ST_ON       = 2'd2,
    ST_END      = 2'd3
  } div_state_e;

  // Magnitude of a two's-complement value; unsigned operands pass through.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] value,
                                                input logic              is_signed);
    return (is_signed && value[DATA_W-1]) ? (~value + DATA_W'(1)) : value;
  endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring radix-2 iteration: shift {rem, quo} left, trial-subtract the
// divisor from the 33-bit partial remainder, and record the quotient bit.
module div_step
  import ex_div_unit_pkg::*;
(
  input  logic [2*DATA_W-1:0] rem_quo_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] rem_quo_o
);

  logic [DATA_W:0]   partial;
  logic              fits;
  logic [DATA_W-1:0] diff;

  // The difference always fits in DATA_W bits whenever the subtraction is kept.
  always_comb begin
    partial = rem_quo_i[2*DATA_W-1:DATA_W-1];
    fits    = (partial >= {1'b0, divisor_i});
    diff    = partial[DATA_W-1:0] - divisor_i;
    if (fits) begin
      rem_quo_o = {diff, rem_quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_quo_o = {rem_quo_i[2*DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage; holds the
// pipeline via stall_request_o until quotient and remainder are ready.
module ex_div_unit
  import ex_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              annul_i,
  output logic              stall_request_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   dvsr_q;
  logic                neg_quo_q, neg_rem_q;
  logic [DATA_W-1:0]   quotient_q, remainder_q;
  logic [DATA_W-1:0]   quo_fix_d, rem_fix_d;

  div_step u_div_step (
    .rem_quo_i (acc_q),
    .divisor_i (dvsr_q),
    .rem_quo_o (acc_d)
  );

  always_comb begin
    quo_fix_d = neg_quo_q ? (~acc_d[DATA_W-1:0] + DATA_W'(1)) : acc_d[DATA_W-1:0];
    rem_fix_d = neg_rem_q ? (~acc_d[2*DATA_W-1:DATA_W] + DATA_W'(1))
                          : acc_d[2*DATA_W-1:DATA_W];
  end

  // Annul wins in every state and leaves the published results untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (annul_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q     <= '0;
            neg_quo_q <= signed_div_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            neg_rem_q <= signed_div_i & dividend_i[DATA_W-1];
            if (divisor_i == '0) begin
              state_q <= ST_DIV_ZERO;
              acc_q   <= {{DATA_W{1'b0}}, dividend_i};
            end else begin
              state_q <= ST_ON;
              acc_q   <= {{DATA_W{1'b0}}, abs_val(dividend_i, signed_div_i)};
              dvsr_q  <= abs_val(divisor_i, signed_div_i);
            end
          end
        end
        ST_DIV_ZERO: begin
          state_q     <= ST_END;
          quotient_q  <= '1;
          remainder_q <= acc_q[DATA_W-1:0];
        end
        ST_ON: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            state_q     <= ST_END;
            quotient_q  <= quo_fix_d;
            remainder_q <= rem_fix_d;
          end
        end
        ST_END:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_request_o = (start_i && !annul_i && rst_n && (state_q != ST_END)) ? STOP : NO_STOP;
  assign result_valid_o  = (state_q == ST_END);
  assign quotient_o      = quotient_q;
  assign remainder_o     = remainder_q;

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Multi-cycle 32-bit integer divider living in the EX stage. It is the requesting side of the stall protocol: while a division is outstanding it raises `stall_request` toward the pipeline stall controller, which freezes PC/IF/ID/EX. It releases the request in the cycle its quotient and remainder are valid for EX to forward to MEM.

## Interface
- `DATA_W`, 32, operand and result width. Fixed at 32 for this core; the counter width is `$clog2(DATA_W)`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX holds a DIV/DIVU; held high by the stalled pipeline until release.
- `signed_div`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start` in IDLE.
- `dividend`  in  32  numerator; sampled in IDLE.
- `divisor`  in  32  denominator; sampled in IDLE.
- `annul`  in  1  cancel due to flush or exception; overrides `start`.
- `stall_request`  out  1  to the stall controller; 1 = STOP.
- `result_valid`  out  1  one-cycle strobe; the results are valid in this cycle.
- `quotient`  out  32  quotient; held until the next accepted operation.
- `remainder`  out  32  remainder; held until the next accepted operation.

## Operation
- FSM states: IDLE, DIV_ZERO, ON, END.
- IDLE, `start` = 1, `annul` = 0:
  - `divisor` = 0 → go to DIV_ZERO.
  - otherwise → go to ON. Latch |dividend| and |divisor| (absolute values only when `signed_div` = 1). Latch the two sign bits. Clear the counter.
- DIV_ZERO → END. Results: quotient = 32'hFFFF_FFFF, remainder = dividend, in both signed and unsigned mode.
- ON: restoring radix-2, one quotient bit per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - On no borrow, keep the difference and set quo[0].
  - After the iteration with counter = 31 → go to END. Apply sign fix in the same edge:
    - negate the quotient if `signed_div` and the operand signs differ;
    - negate the remainder if `signed_div` and the dividend is negative.
  - 0x8000_0000 / -1 signed yields quotient 0x8000_0000, remainder 0. No special case.
- END: `result_valid` = 1, `stall_request` = 0. Unconditionally go to IDLE on the next edge.
- `stall_request` is combinational: `start` & ~`annul` & (state ≠ END).
  - It is asserted in the same cycle a divide first reaches EX.
- `annul` = 1 in any state: next state is IDLE, `stall_request` drops immediately, and no `result_valid` strobe occurs. Registered results are not updated.
- Back-to-back divides: END → IDLE, and IDLE accepts the next `start`. There is one non-stalled gap cycle, in which the pipeline advances.

## Timing
- Reset values (async, `rst` = 0): state IDLE, counter 0, `quotient` 0, `remainder` 0, `result_valid` 0. `stall_request` = 0 while in reset.
- Normal divide, with `start` first high in cycle 0 (IDLE):
  - ON during cycles 1–32, END in cycle 33.
  - `stall_request` high in cycles 0–32 (33 cycles); `result_valid` high in cycle 33 only.
- Divide by zero: DIV_ZERO in cycle 1, END in cycle 2; `stall_request` high in cycles 0–1.
- `start` low in IDLE: no state change and outputs hold.
- `start` falling in ON without `annul` is a protocol violation. The unit finishes anyway and strobes `result_valid`.
- Async reset mid-ON: immediate return to IDLE; the partial result is discarded.

## Structure
- Shared package / global defines:
  - state encoding (IDLE, DIV_ZERO, ON, END);
  - `STOP` / `NO_STOP`;
  - the 32-bit data-bus width macro.
- One natural combinational sub-module, `div_step`. It takes the 64-bit {rem, quo} and the 32-bit divisor, and returns the next {rem, quo}. This keeps the iteration unit-testable.

## Test plan
- DIVU 100 / 7, `start` held → `stall_request` high for 33 cycles; `result_valid` in cycle 33 with quotient 14, remainder 2.
- DIV -7 / 2 → quotient 32'hFFFF_FFFD (-3), remainder 32'hFFFF_FFFF (-1). DIV 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0.
- DIVU 5 / 0 → `stall_request` for 2 cycles; quotient 32'hFFFF_FFFF, remainder 5 in cycle 2.
- `annul` asserted in ON at counter = 10 → `stall_request` 0 that cycle; IDLE next cycle; no `result_valid`; previous quotient/remainder unchanged.
- Reset asserted mid-ON, then released; DIVU 0xFFFF_FFFF / 1 issued → stall 33 cycles, quotient 0xFFFF_FFFF, remainder 0.
- Two consecutive DIVU (9/3, then 10/4) → results 3,0 and 2,2. One cycle with `stall_request` = 0 between the two 33-cycle stall windows.
